// File: rtl/muldiv_unit_if.sv
// HI/LO-class instruction channel between the EXE stage and the multiply/divide unit.
// Latency: n/a (wires only); the unit answers with ready/result/busy.
// Backpressure: EXE holds op_valid and operands until ready, then pulses op_fire.
// Ports: op_valid/op/src1/src2 (instruction), op_fire/wr_disable/flush (pipeline control),
//        ready/result/busy (unit status and MFHI/MFLO data).
interface muldiv_unit_if;
  logic        op_valid;
  logic [7:0]  op;          // one-hot {MTLO,MTHI,MFLO,MFHI,DIVU,DIV,MULTU,MULT}
  logic [31:0] src1;
  logic [31:0] src2;
  logic        op_fire;
  logic        wr_disable;
  logic        flush;
  logic        ready;
  logic [31:0] result;
  logic        busy;

  modport master (
    output op_valid, op, src1, src2, op_fire, wr_disable, flush,
    input  ready, result, busy
  );

  modport slave (
    input  op_valid, op, src1, src2, op_fire, wr_disable, flush,
    output ready, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// MIPS HI/LO unit: MULT/MULTU, DIV/DIVU (radix-2 restoring), MFHI/MFLO, MTHI/MTLO.
// Latency: MULT* ready 2 cycles after op_valid, DIV* 33 cycles, MF/MT combinational.
// Backpressure: ready low stalls EXE; op_fire without ready is ignored; flush aborts.
// Ports: clk, resetn (async active-low), bus (muldiv_unit_if.slave).
module muldiv_unit (
  input  logic          clk,
  input  logic          resetn,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] thi_q, thi_d, tlo_q, tlo_d;
  // opa doubles as the multiplicand and as the dividend/quotient shift register
  logic [31:0] opa_q, opa_d, opb_q, opb_d, rem_q, rem_d;
  logic        sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;

  logic        is_mul, is_div, is_mf, is_mt;
  logic [31:0] abs1, abs2;
  logic [63:0] prod;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] rem_nx, quo_nx;

  assign is_mul = bus.op[0] | bus.op[1];
  assign is_div = bus.op[2] | bus.op[3];
  assign is_mf  = bus.op[4] | bus.op[5];
  assign is_mt  = bus.op[6] | bus.op[7];

  // Magnitudes for signed DIV; 0x80000000 stays 0x80000000, which is its unsigned magnitude.
  assign abs1 = (bus.op[2] & bus.src1[31]) ? (~bus.src1 + 32'd1) : bus.src1;
  assign abs2 = (bus.op[2] & bus.src2[31]) ? (~bus.src2 + 32'd1) : bus.src2;

  // Sign-extending to 64 bits makes one unsigned multiplier serve both MULT and MULTU.
  assign prod = {{32{sgn_q & opa_q[31]}}, opa_q} * {{32{sgn_q & opb_q[31]}}, opb_q};

  // One restoring step: shift next dividend bit into the partial remainder.
  assign trial  = {rem_q, opa_q[31]};
  assign ge     = (trial >= {1'b0, opb_q});
  assign rem_nx = ge ? 32'(trial - {1'b0, opb_q}) : trial[31:0];
  assign quo_nx = {opa_q[30:0], ge};

  assign bus.ready  = (state_q == S_DONE) ||
                      ((state_q == S_IDLE) && bus.op_valid && (is_mf || is_mt));
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.result = (bus.op_valid && bus.op[4]) ? hi_q :
                      (bus.op_valid && bus.op[5]) ? lo_q : 32'd0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    thi_d   = thi_q;
    tlo_d   = tlo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;

    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.op_valid) begin
            if (is_mul) begin
              opa_d   = bus.src1;
              opb_d   = bus.src2;
              sgn_d   = bus.op[0];
              state_d = S_MUL;
            end else if (is_div) begin
              opa_d   = abs1;
              opb_d   = abs2;
              rem_d   = 32'd0;
              cnt_d   = 5'd0;
              qneg_d  = bus.op[2] & (bus.src1[31] ^ bus.src2[31]);
              rneg_d  = bus.op[2] & bus.src1[31];
              state_d = S_DIV;
            end else if (is_mt && bus.op_fire && !bus.wr_disable) begin
              if (bus.op[6]) hi_d = bus.src1;
              if (bus.op[7]) lo_d = bus.src1;
            end
          end
        end
        S_MUL: begin
          thi_d   = prod[63:32];
          tlo_d   = prod[31:0];
          state_d = S_DONE;
        end
        S_DIV: begin
          opa_d = quo_nx;
          rem_d = rem_nx;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            tlo_d   = qneg_q ? (~quo_nx + 32'd1) : quo_nx;
            thi_d   = rneg_q ? (~rem_nx + 32'd1) : rem_nx;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.op_fire) begin
            state_d = S_IDLE;
            if (!bus.wr_disable) begin
              hi_d = thi_q;
              lo_d = tlo_q;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      thi_q   <= 32'd0;
      tlo_q   <= 32'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      rem_q   <= 32'd0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      thi_q   <= thi_d;
      tlo_q   <= tlo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit against an arithmetic HI/LO model.
// Latency: n/a.
// Backpressure: bench waits on ready with a bounded cycle budget.
module tb_muldiv_unit;

  localparam logic [7:0] OP_MULT  = 8'h01;
  localparam logic [7:0] OP_MULTU = 8'h02;
  localparam logic [7:0] OP_DIV   = 8'h04;
  localparam logic [7:0] OP_DIVU  = 8'h08;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h20;
  localparam logic [7:0] OP_MTHI  = 8'h40;
  localparam logic [7:0] OP_MTLO  = 8'h80;

  logic clk = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: architectural MIPS semantics from plain integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [7:0] opc, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 64'd0;
    case (opc)
      OP_MULT:  res = sa * sb;
      OP_MULTU: res = {32'd0, a} * {32'd0, b};
      OP_DIVU:  res = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      OP_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  task automatic idle_inputs();
    bus.op_valid   = 1'b0;
    bus.op         = 8'd0;
    bus.op_fire    = 1'b0;
    bus.wr_disable = 1'b0;
    bus.flush      = 1'b0;
  endtask

  // Starts just after a rising edge; ends just after the commit edge.
  task automatic run_op(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b,
                        input logic wrdis, input bit scramble);
    int lat;
    int exp_lat;
    logic [63:0] r;
    bus.op_valid = 1'b1;
    bus.op       = opc;
    bus.src1     = a;
    bus.src2     = b;
    bus.op_fire  = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bus.ready && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (scramble) begin
        bus.src1 = $urandom;
        bus.src2 = $urandom;
      end
      @(negedge clk);
    end
    exp_lat = (opc == OP_MULT || opc == OP_MULTU) ? 2 : 33;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_in_done", 32'(bus.busy), 32'd1);
    bus.op_fire    = 1'b1;
    bus.wr_disable = wrdis;
    @(posedge clk); #1;
    idle_inputs();
    r = ref_op(opc, a, b);
    if (!wrdis) begin
      m_hi = r[63:32];
      m_lo = r[31:0];
    end
    chk("busy_after_fire", 32'(bus.busy), 32'd0);
  endtask

  task automatic read_hilo(input string tag);
    bus.op_valid = 1'b1;
    bus.op       = OP_MFHI;
    @(negedge clk);
    chk({tag, "_mf_ready"}, 32'(bus.ready), 32'd1);
    chk({tag, "_hi"}, bus.result, m_hi);
    @(posedge clk); #1;
    bus.op = OP_MFLO;
    @(negedge clk);
    chk({tag, "_lo"}, bus.result, m_lo);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic move_to(input logic [7:0] opc, input logic [31:0] v, input logic wrdis);
    bus.op_valid   = 1'b1;
    bus.op         = opc;
    bus.src1       = v;
    bus.op_fire    = 1'b1;
    bus.wr_disable = wrdis;
    @(negedge clk);
    chk("mt_ready", 32'(bus.ready), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    if (!wrdis) begin
      if (opc == OP_MTHI) m_hi = v;
      else m_lo = v;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rops [4];
    logic [7:0]  opc;
    logic [31:0] a, b;
    rops[0] = OP_MULT; rops[1] = OP_MULTU; rops[2] = OP_DIV; rops[3] = OP_DIVU;

    idle_inputs();
    bus.src1 = 32'd0;
    bus.src2 = 32'd0;
    resetn = 1'b0;
    #3;
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    #9 resetn = 1'b1;
    @(posedge clk); #1;

    // Product of -2 and 3; issued on the first edge after reset.
    run_op(OP_MULT, 32'hFFFFFFFE, 32'h00000003, 1'b0, 1'b0);
    read_hilo("mult_neg");

    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    read_hilo("div_neg7_2");

    run_op(OP_DIVU, 32'd100, 32'd0, 1'b0, 1'b0);
    read_hilo("divu_by0");

    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    read_hilo("div_ovf");

    run_op(OP_DIV, 32'd50, 32'd0, 1'b0, 1'b0);
    read_hilo("div_by0");

    move_to(OP_MTHI, 32'h12345678, 1'b0);
    move_to(OP_MTLO, 32'h9ABCDEF0, 1'b0);
    move_to(OP_MTHI, 32'hDEADBEEF, 1'b1);
    read_hilo("mt_load");
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    read_hilo("wr_disable");

    // Flush at iteration 10, with op_fire held high while not ready.
    bus.op_valid = 1'b1;
    bus.op       = OP_DIV;
    bus.src1     = 32'd1000;
    bus.src2     = 32'd7;
    bus.op_fire  = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    chk("div_mid_ready", 32'(bus.ready), 32'd0);
    chk("div_mid_busy", 32'(bus.busy), 32'd1);
    bus.op_valid = 1'b0;
    bus.op_fire  = 1'b0;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_ready", 32'(bus.ready), 32'd0);
    @(posedge clk); #1;
    read_hilo("after_flush");
    run_op(OP_MULT, 32'd3, 32'd4, 1'b0, 1'b0);
    read_hilo("mult_3x4");

    // Back-to-back randomized ops with operands scrambled while in flight.
    for (int i = 0; i < 16; i++) begin
      opc = rops[$urandom_range(0, 3)];
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (opc == OP_DIV && b == 32'd0 && a[31]) b = 32'd1;
      run_op(opc, a, b, ($urandom_range(0, 4) == 0), 1'b1);
      if (i % 4 == 3) read_hilo("rand");
    end
    read_hilo("rand_end");

    // Reset in the middle of a DIVU.
    move_to(OP_MTHI, 32'hA5A5A5A5, 1'b0);
    bus.op_valid = 1'b1;
    bus.op       = OP_DIVU;
    bus.src1     = 32'd1000;
    bus.src2     = 32'd3;
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.ready), 32'd0);
    chk("mid_rst_result", bus.result, 32'd0);
    bus.op_valid = 1'b1;
    bus.op       = OP_MFHI;
    #1;
    chk("mid_rst_hi", bus.result, 32'd0);
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(posedge clk); #1;
    read_hilo("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and resetn.
REQ-002 Port list, one per line:
- clk  in  1  clock
- resetn  in  1  async active-low reset
- op_valid  in  1  EXE holds a valid HI/LO-class instruction
- op  in  8  one-hot {MTLO,MTHI,MFLO,MFHI,DIVU,DIV,MULTU,MULT} (bit7..bit0)
- src1  in  32  rs value
- src2  in  32  rt value
- op_fire  in  1  EXE advances the instruction this cycle
- wr_disable  in  1  suppress HI/LO commit (exception or older exception downstream)
- flush  in  1  pipeline flush (eret or exception)
- ready  out  1  result available; EXE may advance
- result  out  32  MFHI/MFLO data, else 0
- busy  out  1  FSM not IDLE

Function
REQ-003 The FSM SHALL have states IDLE, MUL, DIV and DONE, with a 5-bit iteration counter.
REQ-004 In IDLE, when op_valid and MULT/MULTU are set, it SHALL latch the operands and go to MUL.
REQ-005 In IDLE, when op_valid and DIV/DIVU are set, it SHALL latch the operands, clear the counter and go to DIV.
REQ-006 MUL SHALL form a 64-bit product (signed for MULT, unsigned for MULTU) into temporary registers {thi,tlo} and go to DONE after 1 cycle.
REQ-007 DIV SHALL run a radix-2 restoring divide on magnitudes, one quotient bit per cycle, for exactly 32 cycles (counter 0..31), then go to DONE.
REQ-008 DIV sign rule: the quotient SHALL be negated iff the signs differ; the remainder SHALL take the dividend's sign; tlo=quotient, thi=remainder.
REQ-009 Divide by zero SHALL still take 32 cycles and yield quotient 0xFFFFFFFF (unsigned magnitude path) and remainder = dividend.
REQ-010 DIV of 0x80000000 by 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-011 In DONE, ready SHALL be 1; on op_fire the FSM SHALL go to IDLE.
REQ-012 While the FSM is in MUL or DIV, ready SHALL be 0.
REQ-013 ready SHALL be combinationally 1 in IDLE when op_valid and op is MFHI/MFLO/MTHI/MTLO.
REQ-014 ready SHALL be 0 in IDLE when op_valid=0.
REQ-015 result SHALL be HI for MFHI and LO for MFLO (current architectural value), and 0 otherwise.
REQ-016 Commit of a mul/div on the op_fire cycle, with wr_disable=0: HI<=thi, LO<=tlo.
REQ-017 Commit of MTHI on the op_fire cycle, with wr_disable=0: HI<=src1.
REQ-018 Commit of MTLO on the op_fire cycle, with wr_disable=0: LO<=src1.
REQ-019 When wr_disable=1 on the op_fire cycle, the FSM SHALL still return to IDLE and HI/LO SHALL be unchanged.
REQ-020 flush SHALL force the FSM to IDLE next cycle from any state, with no HI/LO write, and SHALL take priority over op_fire.
REQ-021 op_fire while ready=0 SHALL be ignored; no write and no state change.
REQ-022 Operand and op inputs SHALL be sampled only at IDLE->MUL/DIV; later input changes SHALL not affect an operation in flight.
REQ-023 Back-to-back ops: a new mul/div SHALL be accepted the cycle after returning to IDLE.
REQ-024 MFHI directly after a committed MULT SHALL see the new HI.
REQ-025 busy SHALL be 1 in MUL, DIV and DONE.
REQ-026 Latency from the first op_valid cycle to ready=1 SHALL be: MULT/MULTU 2 cycles, DIV/DIVU 33 cycles, MF/MT 0 cycles.

Reset
REQ-027 resetn low SHALL asynchronously set FSM=IDLE, counter=0, HI=0, LO=0, thi=tlo=0, ready=0, result=0, busy=0.
REQ-028 Reset mid-divide SHALL abandon the operation without writing HI/LO.
REQ-029 The first operation after resetn deasserts SHALL be accepted on the first clock edge.

Verification
REQ-030 MULT 0xFFFFFFFE x 0x00000003, op_fire on ready, then MFHI/MFLO -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; ready 2 cycles after op_valid.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2 -> ready after 33 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
REQ-032 DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100.
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF, wr_disable=1 at op_fire -> HI/LO keep prior values (0x12345678/0x9ABCDEF0 loaded via MTHI/MTLO); FSM returns to IDLE.
REQ-034 DIV started, flush asserted at iteration 10 -> IDLE next cycle; busy=0; HI/LO unchanged; a following MULT 3x4 gives LO=12.
REQ-035 resetn pulsed low at iteration 20 of DIVU -> all outputs 0 immediately; HI=LO=0 afterwards.
